// File: rtl/me_req_ctrl.sv
// me_req_ctrl: operator front end for the motion-estimation core.
// Debounces active-low push-keys, turns start/stop/mode presses into the
// req/ack four-phase handshake towards me_top, and captures search results.
module me_req_ctrl #(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SAD_W           = 16,
  parameter int unsigned MVEC_W          = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 1048576,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NKEYS-1:0]  key_n,
  output logic [NKEYS-1:0]  key_fall,
  output logic              req,
  input  logic              ack,
  input  logic [SAD_W-1:0]  min_sad,
  input  logic [MVEC_W-1:0] min_mvec,
  output logic [SAD_W-1:0]  res_sad,
  output logic [MVEC_W-1:0] res_mvec,
  output logic              res_valid,
  output logic              done,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              timeout,
  output logic              busy,
  output logic              mode
);

  // Debounce counter only ever holds 0..DEBOUNCE_CYCLES-1.
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Timeout counter only ever holds 0..TIMEOUT_CYCLES-1.
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKLO = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Per-key synchroniser + debouncer + falling-edge pulse
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    logic            sync1;
    logic            sync2;
    logic            stable;
    logic [DB_W-1:0] cnt;
    logic            fall;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1  <= 1'b1;
        sync2  <= 1'b1;
        stable <= 1'b1;
        cnt    <= '0;
        fall   <= 1'b0;
      end else begin
        sync1 <= key_n[k];
        sync2 <= sync1;
        if (sync2 == stable) begin
          cnt  <= '0;
          fall <= 1'b0;
        end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync2;
          cnt    <= '0;
          fall   <= stable;
        end else begin
          cnt  <= cnt + DB_W'(1);
          fall <= 1'b0;
        end
      end
    end

    assign key_fall[k] = fall;
  end

  logic start;
  logic stop;
  logic toggle;

  assign start  = key_fall[0];
  assign stop   = key_fall[1];
  assign toggle = key_fall[2];

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  state_t            state;
  state_t            state_next;
  logic [TO_W-1:0]   tcnt;
  logic [TO_W-1:0]   tcnt_next;
  logic              last_cap;
  logic              last_cap_next;
  logic              stop_lat;
  logic              stop_lat_next;
  logic [SAD_W-1:0]  res_sad_next;
  logic [MVEC_W-1:0] res_mvec_next;
  logic              res_valid_next;
  logic              done_next;
  logic [CNT_W-1:0]  run_cnt_next;
  logic              timeout_next;

  // State, result and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      last_cap  <= 1'b0;
      stop_lat  <= 1'b0;
      req       <= 1'b0;
      busy      <= 1'b0;
      res_sad   <= '0;
      res_mvec  <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      run_cnt   <= '0;
      timeout   <= 1'b0;
      mode      <= 1'b0;
    end else begin
      state     <= state_next;
      tcnt      <= tcnt_next;
      last_cap  <= last_cap_next;
      stop_lat  <= stop_lat_next;
      req       <= (state_next == REQ);
      busy      <= (state_next != IDLE);
      res_sad   <= res_sad_next;
      res_mvec  <= res_mvec_next;
      res_valid <= res_valid_next;
      done      <= done_next;
      run_cnt   <= run_cnt_next;
      timeout   <= timeout_next;
      mode      <= mode ^ toggle;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    tcnt_next      = tcnt;
    last_cap_next  = last_cap;
    stop_lat_next  = stop_lat;
    res_sad_next   = res_sad;
    res_mvec_next  = res_mvec;
    res_valid_next = res_valid;
    done_next      = 1'b0;
    run_cnt_next   = run_cnt;
    timeout_next   = timeout;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next     = REQ;
          res_valid_next = 1'b0;
          timeout_next   = 1'b0;
          tcnt_next      = '0;
        end
      end

      REQ: begin
        tcnt_next     = tcnt + TO_W'(1);
        stop_lat_next = 1'b0;
        if (ack) begin
          res_sad_next   = min_sad;
          res_mvec_next  = min_mvec;
          res_valid_next = 1'b1;
          done_next      = 1'b1;
          run_cnt_next   = run_cnt + CNT_W'(1);
          last_cap_next  = 1'b1;
          state_next     = ACKLO;
        end else if (stop) begin
          last_cap_next = 1'b0;
          state_next    = ACKLO;
        end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_next  = 1'b1;
          last_cap_next = 1'b0;
          state_next    = ACKLO;
        end
      end

      ACKLO: begin
        if (stop) begin
          stop_lat_next = 1'b1;
        end
        if (!ack) begin
          stop_lat_next = 1'b0;
          // Relaunch keeps res_valid: the previous result stays readable.
          if (mode && !stop && !stop_lat && last_cap) begin
            state_next = REQ;
            tcnt_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
